multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the existing single-issue datapath: instruction memory (PC_W-bit pc), control unit (instruction → op), register file (two read ports), ALU (DATA_W operands).
- Steps pc, fetches each instruction, reads operands, executes, and writes the ALU result back to the register file.
- On a start pulse it runs the program from pc 0 to a halt instruction or the last address, then reports done.
- Replaces the free-running pc increment used by the current benches with a clocked controller.

Parameters:
- PC_W, 2, program counter width; program length is 2**PC_W.
- RADDR_W, 3, register file address width.
- DATA_W, 8, operand/result width.
- INSTR_W, 3, instruction width.
- OP_W, 3, ALU op width.
- HALT_INSTR, 3'b111, instruction encoding that ends the program without writeback.
- CNT_W, 8, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a program run from IDLE.
- abort  in  1  synchronous; returns to IDLE from any state.
- cfg_rs1  in  RADDR_W  source register 1, sampled on start.
- cfg_rs2  in  RADDR_W  source register 2, sampled on start.
- cfg_rd  in  RADDR_W  destination register, sampled on start.
- pc_o  out  PC_W  to instruction memory.
- instr_i  in  INSTR_W  from instruction memory (combinational on pc_o).
- instr_o  out  INSTR_W  latched instruction, to control unit.
- op_i  in  OP_W  from control unit (combinational on instr_o).
- rf_r1  out  RADDR_W  register file read address 1.
- rf_r2  out  RADDR_W  register file read address 2.
- rf_d1  in  DATA_W  read data 1.
- rf_d2  in  DATA_W  read data 2.
- alu_a  out  DATA_W  ALU operand a.
- alu_b  out  DATA_W  ALU operand b.
- alu_op  out  OP_W  ALU op.
- alu_result  in  DATA_W  ALU result.
- rf_we  out  1  register file write enable.
- rf_waddr  out  RADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- busy  out  1  high from FETCH through WRITEBACK.
- done  out  1  one-cycle pulse at end of run.
- retired_cnt  out  CNT_W  instructions written back this run.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and internal registers are 0; state is IDLE.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, DONE, plus STALL when SINGLE_STEP_EN is defined.
- IDLE: start=1 latches cfg_rs1/rs2/rd, sets pc_o=0, clears retired_cnt, goes to FETCH. start is ignored in every other state.
- FETCH: instr_i is latched into instr_o; next state DECODE.
- DECODE:
  - If instr_o==HALT_INSTR, go to DONE; no writeback, no counter increment.
  - Otherwise latch op_i into alu_op, rf_d1 into alu_a, rf_d2 into alu_b, and go to EXECUTE.
- rf_r1/rf_r2 hold the latched cfg_rs1/cfg_rs2 from start until the next start.
- EXECUTE: alu_result is latched into rf_wdata, cfg_rd into rf_waddr; next state WRITEBACK.
- WRITEBACK:
  - rf_we=1 for exactly this cycle; retired_cnt increments, wrapping at 2**CNT_W-1 to 0.
  - If pc_o==2**PC_W-1, go to DONE (pc_o holds, no wrap).
  - Otherwise pc_o increments and the next state is FETCH.
- DONE: done=1 for one cycle; next state IDLE. busy=0 in IDLE and DONE.
- Latency: 4 cycles per instruction.
  - Start sampled at edge N: first rf_we in cycle N+4, k-th in N+4k.
  - With a full program of 4 instructions, done in cycle N+17.
- abort:
  - Highest priority; the next state is IDLE.
  - rf_we is forced to 0 in the abort cycle.
  - done is not pulsed; pc_o and retired_cnt hold their values.
- rf_we is never asserted outside WRITEBACK.

Optional Feature:
- Macro: MULTICYCLE_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - After WRITEBACK that would go to FETCH, the FSM enters STALL (busy=1) and stays there until step=1, then goes to FETCH.
  - abort is honoured in STALL.
- Undefined: no step port, no STALL state; WRITEBACK goes directly to FETCH.

Test Plan:
- Bench models: instr memory = {000,001,010,011}; control unit op=instr; ALU op0=a+b, op1=a-b, op2=a&b, op3=a|b; register file r0=5, r1=3. Drive cfg_rs1=0, cfg_rs2=1, cfg_rd=2, then pulse start → rf_we in cycles N+4/8/12/16 with rf_wdata 8, 2, 1, 7; done in cycle N+17; retired_cnt=4.
- Instruction memory {000,111,xxx,xxx}, start → one write of 8, DONE after the DECODE of pc=1, done pulse, retired_cnt=1, no second rf_we.
- Pulse abort in EXECUTE of pc=2 → no rf_we that cycle, IDLE next cycle, done stays 0, busy=0, pc_o=2.
- start pulsed while busy → ignored; write sequence identical to the first scenario.
- rst_n low in WRITEBACK → rf_we drops immediately (asynchronous), all outputs 0; after release, start reruns from pc 0.
- With SINGLE_STEP_EN defined: after the first write the FSM holds in STALL for 10 cycles with busy=1 and no FETCH; step pulse → next rf_we 4 cycles after leaving STALL.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle fetch/decode/execute/writeback sequencer for the
//            single-issue datapath. Optional macro MULTICYCLE_CTRL_SINGLE_STEP_EN
//            adds a step input and a STALL state between instructions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int                   PC_W       = 2,
  parameter int                   RADDR_W    = 3,
  parameter int                   DATA_W     = 8,
  parameter int                   INSTR_W    = 3,
  parameter int                   OP_W       = 3,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 3'b111,
  parameter int                   CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [RADDR_W-1:0] cfg_rs1,
  input  logic [RADDR_W-1:0] cfg_rs2,
  input  logic [RADDR_W-1:0] cfg_rd,
  output logic [PC_W-1:0]    pc_o,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [INSTR_W-1:0] instr_o,
  input  logic [OP_W-1:0]    op_i,
  output logic [RADDR_W-1:0] rf_r1,
  output logic [RADDR_W-1:0] rf_r2,
  input  logic [DATA_W-1:0]  rf_d1,
  input  logic [DATA_W-1:0]  rf_d2,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   retired_cnt
);

`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_DONE      = 3'd5,
    S_STALL     = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_DONE      = 3'd5
  } state_t;
`endif

  localparam logic [PC_W-1:0] c_pc_last = '1;

  state_t             r_state;
  state_t             w_next;
  logic [RADDR_W-1:0] r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_FETCH;
      S_FETCH:     w_next = S_DECODE;
      S_DECODE:    w_next = (instr_o == HALT_INSTR) ? S_DONE : S_EXECUTE;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: begin
        if (pc_o == c_pc_last) w_next = S_DONE;
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
        else                   w_next = S_STALL;
`else
        else                   w_next = S_FETCH;
`endif
      end
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
      S_STALL:     if (step) w_next = S_FETCH;
`endif
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    // abort overrides every transition, including a start in IDLE
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    rf_we = (r_state == S_WRITEBACK) && !abort;
    done  = (r_state == S_DONE);
    busy  = (r_state == S_FETCH) || (r_state == S_DECODE) ||
            (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    if (r_state == S_STALL) busy = 1'b1;
`endif
  end

  // Datapath registers freeze during an abort cycle so pc/count keep their values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o        <= '0;
      instr_o     <= '0;
      rf_r1       <= '0;
      rf_r2       <= '0;
      r_rd        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      retired_cnt <= '0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            rf_r1       <= cfg_rs1;
            rf_r2       <= cfg_rs2;
            r_rd        <= cfg_rd;
            pc_o        <= '0;
            retired_cnt <= '0;
          end
        end
        S_FETCH: instr_o <= instr_i;
        S_DECODE: begin
          if (instr_o != HALT_INSTR) begin
            alu_op <= op_i;
            alu_a  <= rf_d1;
            alu_b  <= rf_d2;
          end
        end
        S_EXECUTE: begin
          rf_wdata <= alu_result;
          rf_waddr <= r_rd;
        end
        S_WRITEBACK: begin
          retired_cnt <= retired_cnt + CNT_W'(1);
          if (pc_o != c_pc_last) pc_o <= pc_o + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
